// File: rtl/i2c_target_mem_pkg.sv
// Shared I2C definitions: target FSM states, bus-condition encodings and pointer helpers.
// Imported by the bus synchronizer, the target top level and the I2C master.
package i2c_target_mem_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } i2c_state_e;

    typedef enum logic [1:0] {
        BusIdle  = 2'b00,
        BusStart = 2'b01,
        BusStop  = 2'b10
    } bus_cond_e;

    localparam int unsigned PtrW        = 4;
    localparam int unsigned BitCntW     = 4;
    localparam logic [3:0]  BitsPerByte = 4'd8;

    // Next pointer value, wrapping at the end of the memory.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr,
                                                input int unsigned     depth);
        if (32'(ptr) == depth - 32'd1) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for raw SCL/SDA plus SCL edge and START/STOP detection.
// All outputs are combinational decodes of the synchronized copies.
module i2c_bus_sync
    import i2c_target_mem_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      scl_in,
    input  logic      sda_in,
    output logic      sda,
    output logic      scl_rise,
    output logic      scl_fall,
    output bus_cond_e bus_cond
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;
    logic       scl;
    logic       start_det;
    logic       stop_det;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_in};
        sda_sync_d = {sda_sync_q[0], sda_in};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Reset to the idle-bus level so releasing reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    always_comb begin
        scl       = scl_sync_q[1];
        sda       = sda_sync_q[1];
        scl_rise  = scl & ~scl_prev_q;
        scl_fall  = ~scl & scl_prev_q;
        start_det = scl & sda_prev_q & ~sda;
        stop_det  = scl & ~sda_prev_q & sda;
        bus_cond  = BusIdle;
        if (start_det) begin
            bus_cond = BusStart;
        end else if (stop_det) begin
            bus_cond = BusStop;
        end
    end

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target exposing a small byte memory: write sets pointer then stores data,
// read streams bytes from the pointer; the pointer auto-increments and wraps.
module i2c_target_mem
    import i2c_target_mem_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scl_in,
    input  logic            sda_in,
    output logic            sda_oe,
    output logic            busy,
    output logic            done,
    output logic            wr_stb,
    output logic [PtrW-1:0] wr_addr,
    output logic [7:0]      wr_data
);

    logic      sda;
    logic      scl_rise;
    logic      scl_fall;
    bus_cond_e bus_cond;

    i2c_bus_sync u_bus_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .bus_cond (bus_cond)
    );

    i2c_state_e         state_q, state_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic               rw_q, rw_d;
    logic               nack_q, nack_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_stb_q, wr_stb_d;
    logic [PtrW-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               mem_we;

    logic [7:0]         mem_q [MEM_DEPTH];
    logic [PtrW-1:0]    ptr_nxt;
    logic [7:0]         rd_cur;
    logic [7:0]         rd_nxt;

    assign ptr_nxt = ptr_inc(ptr_q, MEM_DEPTH);
    assign rd_cur  = mem_q[ptr_q];
    assign rd_nxt  = mem_q[ptr_nxt];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        nack_d    = nack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;

        if (bus_cond == BusStart) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (bus_cond == BusStop) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = busy_q;
        end else if (scl_rise) begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    shift_d   = {shift_q[6:0], sda};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                StRdata:    bit_cnt_d = bit_cnt_q + 1'b1;
                StRdataAck: nack_d = sda;
                default:    ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                StAddr: begin
                    if (bit_cnt_q == BitsPerByte) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = StAddrAck;
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d  = StRdata;
                        shift_d  = rd_cur;
                        sda_oe_d = ~rd_cur[7];
                    end else begin
                        state_d  = StPtr;
                        sda_oe_d = 1'b0;
                    end
                end
                StPtr: begin
                    if (bit_cnt_q == BitsPerByte) begin
                        state_d  = StPtrAck;
                        ptr_d    = shift_q[PtrW-1:0];
                        sda_oe_d = 1'b1;
                    end
                end
                StPtrAck: begin
                    state_d   = StWdata;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                StWdata: begin
                    if (bit_cnt_q == BitsPerByte) begin
                        state_d   = StWdataAck;
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = shift_q;
                        sda_oe_d  = 1'b1;
                    end
                end
                StWdataAck: begin
                    state_d   = StWdata;
                    ptr_d     = ptr_nxt;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                end
                StRdata: begin
                    if (bit_cnt_q == BitsPerByte) begin
                        state_d  = StRdataAck;
                        sda_oe_d = 1'b0;
                        nack_d   = 1'b1;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                StRdataAck: begin
                    // A NACK parks in idle with SDA released; busy holds until STOP.
                    if (!nack_q) begin
                        state_d   = StRdata;
                        ptr_d     = ptr_nxt;
                        shift_d   = rd_nxt;
                        sda_oe_d  = ~rd_nxt[7];
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= shift_q;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
